// File: rtl/pipeline_control.sv
// Pipeline hazard/branch/halt controller: a four-state Moore FSM that
// drives PC and pipeline-register enables from decode/execute status.
module pipeline_control #(
    parameter int MUL_CYCLES   = 3,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        id_valid,
    input  logic [15:0] id_opcode,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [15:0] ex_opcode,
    input  logic [4:0]  ex_dest,
    input  logic        ex_branch,
    input  logic [31:0] ex_target,
    input  logic        resume,
    output logic        pc_write,
    output logic        pc_sel,
    output logic [31:0] pc_target,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        halted,
    output logic [1:0]  state,
    output logic [7:0]  stall_count
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    // ADD..XOR, MOV, ADI, MUL write a destination register
    localparam logic [15:0] WR_MASK  = 16'h1CFF;
    localparam logic [3:0]  FLUSH_LD = 4'(FLUSH_CYCLES);
    localparam logic [3:0]  MUL_LD   = (MUL_CYCLES > 1) ? 4'(MUL_CYCLES - 1) : 4'd1;
    localparam logic        MUL_MULTI = (MUL_CYCLES > 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        pc_sel_q, pc_sel_d;
    logic [31:0] pc_target_q, pc_target_d;
    logic [7:0]  stall_count_q, stall_count_d;

    logic id_onehot;
    logic is_hlt;
    logic is_mul;
    logic hazard;

    always_comb begin
        id_onehot = (id_opcode != 16'd0)
                 && ((id_opcode & (id_opcode - 16'd1)) == 16'd0);
        is_hlt = id_valid & id_onehot & id_opcode[13];
        is_mul = id_valid & id_onehot & id_opcode[12];
        hazard = id_valid & (|(ex_opcode & WR_MASK))
               & ((ex_dest == id_rs) | (ex_dest == id_rt));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_RUN;
            cnt_q         <= 4'd0;
            pc_sel_q      <= 1'b0;
            pc_target_q   <= 32'd0;
            stall_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pc_sel_q      <= pc_sel_d;
            pc_target_q   <= pc_target_d;
            stall_count_q <= stall_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_sel_d    = 1'b0;
        pc_target_d = pc_target_q;
        stall_count_d = stall_count_q;
        if (state_q == ST_STALL && stall_count_q != 8'hFF)
            stall_count_d = stall_count_q + 8'd1;
        unique case (state_q)
            ST_RUN: begin
                if (ex_branch) begin
                    state_d     = ST_FLUSH;
                    cnt_d       = FLUSH_LD;
                    pc_sel_d    = 1'b1;
                    pc_target_d = ex_target;
                end else if (is_hlt) begin
                    state_d = ST_HALT;
                end else if (hazard) begin
                    state_d = ST_STALL;
                    cnt_d   = is_mul ? MUL_LD : 4'd1;
                end else if (is_mul && MUL_MULTI) begin
                    state_d = ST_STALL;
                    cnt_d   = MUL_LD;
                end
            end
            ST_STALL: begin
                if (ex_branch) begin
                    state_d     = ST_FLUSH;
                    cnt_d       = FLUSH_LD;
                    pc_sel_d    = 1'b1;
                    pc_target_d = ex_target;
                end else if (cnt_q == 4'd1) begin
                    state_d = ST_RUN;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == 4'd1) begin
                    state_d = ST_RUN;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HALT: begin
                if (resume)
                    state_d = ST_RUN;
            end
        endcase
    end

    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        halted       = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
            end
            ST_STALL: begin
                id_ex_bubble = 1'b1;
            end
            ST_FLUSH: begin
                pc_write     = pc_sel_q;
                if_id_write  = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end
            ST_HALT: begin
                id_ex_bubble = 1'b1;
                halted       = 1'b1;
            end
        endcase
    end

    assign pc_sel      = pc_sel_q;
    assign pc_target   = pc_target_q;
    assign state       = state_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_control.sv
// Scoreboard bench for pipeline_control: directed scenarios plus random
// traffic, checked against a cycle-level behavioural model.
module tb_pipeline_control;

    localparam int MULC = 3;
    localparam int FLC  = 2;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        id_valid;
    logic [15:0] id_opcode;
    logic [4:0]  id_rs, id_rt;
    logic [15:0] ex_opcode;
    logic [4:0]  ex_dest;
    logic        ex_branch;
    logic [31:0] ex_target;
    logic        resume;
    logic        pc_write, pc_sel, if_id_write, if_id_flush;
    logic        id_ex_bubble, halted;
    logic [31:0] pc_target;
    logic [1:0]  state;
    logic [7:0]  stall_count;

    pipeline_control #(.MUL_CYCLES(MULC), .FLUSH_CYCLES(FLC)) dut (
        .clock(clock), .reset_n(reset_n),
        .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt),
        .ex_opcode(ex_opcode), .ex_dest(ex_dest),
        .ex_branch(ex_branch), .ex_target(ex_target),
        .resume(resume),
        .pc_write(pc_write), .pc_sel(pc_sel), .pc_target(pc_target),
        .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .halted(halted),
        .state(state), .stall_count(stall_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        pc_write;
        logic        pc_sel;
        logic [31:0] pc_target;
        logic        if_id_write;
        logic        if_id_flush;
        logic        id_ex_bubble;
        logic        halted;
        logic [1:0]  state;
        logic [7:0]  stall_count;
    } exp_t;

    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    string phase  = "init";

    // Model: mode 0 run, 1 stall, 2 flush, 3 halt; left = cycles remaining
    int          m_mode, m_left, m_first, m_stalls;
    logic [31:0] m_tgt;

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s [%s] actual=%h required=%h", name, phase, act, req);
        end
    endtask

    function automatic bit writes_reg(logic [15:0] op);
        int wr[11] = '{0, 1, 2, 3, 4, 5, 6, 7, 10, 11, 12};
        foreach (wr[i]) if (op[wr[i]]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_first = 0; m_stalls = 0; m_tgt = 32'd0;
    endtask

    task automatic model_step();
        bit single, hlt, mul, haz;
        if (!reset_n) begin
            model_reset();
            return;
        end
        single = ($countones(id_opcode) == 1);
        hlt = id_valid && single && id_opcode[13];
        mul = id_valid && single && id_opcode[12];
        haz = id_valid && writes_reg(ex_opcode)
              && (ex_dest == id_rs || ex_dest == id_rt);
        if (m_mode == 1 && m_stalls < 255) m_stalls++;
        m_first = 0;
        if (ex_branch && (m_mode == 0 || m_mode == 1)) begin
            m_mode = 2; m_left = FLC; m_first = 1; m_tgt = ex_target;
        end else begin
            case (m_mode)
                0: begin
                    if (hlt) m_mode = 3;
                    else if (haz) begin
                        m_mode = 1;
                        m_left = mul ? ((MULC - 1 > 1) ? MULC - 1 : 1) : 1;
                    end else if (mul && MULC > 1) begin
                        m_mode = 1; m_left = MULC - 1;
                    end
                end
                1, 2: begin
                    if (m_left == 1) m_mode = 0;
                    else m_left--;
                end
                default: if (resume) m_mode = 0;
            endcase
        end
    endtask

    function automatic exp_t model_out();
        exp_t e = '0;
        e.state       = 2'(m_mode);
        e.stall_count = 8'(m_stalls);
        e.pc_target   = m_tgt;
        e.pc_sel      = (m_first != 0);
        case (m_mode)
            0: begin e.pc_write = 1; e.if_id_write = 1; end
            1: e.id_ex_bubble = 1;
            2: begin
                e.pc_write = (m_first != 0); e.if_id_write = 1;
                e.if_id_flush = 1; e.id_ex_bubble = 1;
            end
            default: begin e.id_ex_bubble = 1; e.halted = 1; end
        endcase
        return e;
    endfunction

    initial begin : monitor
        exp_t a, e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.pc_write = pc_write; a.pc_sel = pc_sel;
                a.pc_target = pc_target; a.if_id_write = if_id_write;
                a.if_id_flush = if_id_flush; a.id_ex_bubble = id_ex_bubble;
                a.halted = halted; a.state = state; a.stall_count = stall_count;
                chk("scoreboard", 64'(a), 64'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        model_step();
        exp_q.push_back(model_out());
        #2;
    endtask

    task automatic idle();
        id_valid = 0; id_opcode = 16'h4000; id_rs = 5'd1; id_rt = 5'd2;
        ex_opcode = 16'h4000; ex_dest = 5'd0; ex_branch = 0;
        ex_target = 32'd0; resume = 0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        #1;
        chk("async_state", 64'(state), 64'd0);
        chk("async_stall_count", 64'(stall_count), 64'd0);
        chk("async_pc_sel", 64'(pc_sel), 64'd0);
        chk("async_pc_target", 64'(pc_target), 64'd0);
        model_reset();
        tick();
        reset_n = 1;
        idle();
    endtask

    initial begin : driver
        int pick;
        reset_n = 0;
        idle();
        model_reset();
        #1;
        chk("reset_state", 64'(state), 64'd0);
        chk("reset_pc_write", 64'(pc_write), 64'd1);
        tick();
        reset_n = 1;

        phase = "hazard_stall";
        do_reset();
        ex_opcode = 16'h0001; ex_dest = 5'd5;
        id_valid = 1; id_opcode = 16'h0001; id_rs = 5'd5; id_rt = 5'd9;
        tick();
        chk("haz_state", 64'(state), 64'd1);
        chk("haz_pc_write", 64'(pc_write), 64'd0);
        idle();
        tick();
        chk("haz_count", 64'(stall_count), 64'd1);
        chk("haz_back_run", 64'(state), 64'd0);
        tick();

        phase = "mul_stall";
        do_reset();
        id_valid = 1; id_opcode = 16'h1000;
        tick();
        idle();
        tick();
        chk("mul_still_stall", 64'(state), 64'd1);
        tick();
        chk("mul_count", 64'(stall_count), 64'd2);
        chk("mul_run", 64'(state), 64'd0);

        phase = "branch_flush";
        do_reset();
        ex_branch = 1; ex_target = 32'h0000_0040;
        tick();
        idle();
        chk("br1_pc_sel", 64'(pc_sel), 64'd1);
        chk("br1_pc_write", 64'(pc_write), 64'd1);
        chk("br1_target", 64'(pc_target), 64'h40);
        chk("br1_flush", 64'(if_id_flush), 64'd1);
        tick();
        chk("br2_pc_sel", 64'(pc_sel), 64'd0);
        chk("br2_pc_write", 64'(pc_write), 64'd0);
        chk("br2_flush", 64'(if_id_flush), 64'd1);
        tick();
        chk("br_run", 64'(state), 64'd0);

        phase = "branch_priority";
        do_reset();
        ex_branch = 1; ex_target = 32'h1234;
        id_valid = 1; id_opcode = 16'h2000;
        ex_opcode = 16'h0001; ex_dest = 5'd3; id_rs = 5'd3;
        tick();
        chk("prio_flush", 64'(state), 64'd2);
        chk("prio_not_halted", 64'(halted), 64'd0);
        idle();
        tick();
        tick();

        phase = "halt";
        do_reset();
        id_valid = 1; id_opcode = 16'h2000;
        tick();
        idle();
        chk("halt_halted", 64'(halted), 64'd1);
        ex_branch = 1; ex_target = 32'hDEAD;
        tick();
        ex_branch = 0;
        tick();
        chk("halt_ignore_br", 64'(state), 64'd3);
        resume = 1;
        tick();
        resume = 0;
        chk("resume_run", 64'(state), 64'd0);
        chk("resume_halted", 64'(halted), 64'd0);

        phase = "reset_mid_mul";
        do_reset();
        id_valid = 1; id_opcode = 16'h1000;
        tick();
        idle();
        do_reset();

        phase = "saturate";
        ex_opcode = 16'h0001; ex_dest = 5'd7;
        id_valid = 1; id_opcode = 16'h0002; id_rs = 5'd7;
        repeat (600) tick();
        chk("sat_count", 64'(stall_count), 64'd255);
        idle();

        phase = "random";
        do_reset();
        repeat (3000) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                id_valid = ($urandom_range(0, 3) != 0);
                pick = $urandom_range(0, 14);
                if (pick == 13 && $urandom_range(0, 3) != 0) pick = 14;
                if ($urandom_range(0, 7) == 0) id_opcode = 16'($urandom);
                else id_opcode = 16'(1) << pick;
                if ($urandom_range(0, 7) == 0) ex_opcode = 16'($urandom);
                else ex_opcode = 16'(1) << $urandom_range(0, 14);
                ex_dest = 5'($urandom_range(0, 7));
                id_rs = 5'($urandom_range(0, 7));
                id_rt = 5'($urandom_range(0, 7));
                ex_branch = ($urandom_range(0, 9) == 0);
                ex_target = $urandom;
                resume = ($urandom_range(0, 5) == 0);
                tick();
            end
        end

        phase = "drain";
        idle();
        tick();
        @(posedge clock);
        #3;
        chk("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_control.md
PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 Parameter MUL_CYCLES, default 3, execute occupancy of a MUL in cycles (legal 1..16).
REQ-002 Parameter FLUSH_CYCLES, default 2, bubble cycles after a taken branch (legal 1..15).
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 id_valid  in  1  decode stage holds a valid instruction.
REQ-006 id_opcode  in  16  one-hot opcode in decode (bit0 ADD, 1 SUB, 2 LI, 3 SHL, 4 SHR, 5 AND, 6 OR, 7 XOR, 8 BR, 9 BNE, 10 MOV, 11 ADI, 12 MUL, 13 HLT, 14 NOP).
REQ-007 id_rs, id_rt  in  5 each  decode source register addresses.
REQ-008 ex_opcode  in  16  one-hot opcode currently in execute, same encoding.
REQ-009 ex_dest  in  5  execute destination register address.
REQ-010 ex_branch  in  1  execute reports branch taken this cycle.
REQ-011 ex_target  in  32  branch target PC, valid when ex_branch=1.
REQ-012 resume  in  1  single-cycle pulse leaving HALT.
REQ-013 pc_write  out  1  PC register update enable.
REQ-014 pc_sel  out  1  1 = PC loads pc_target, 0 = PC+1.
REQ-015 pc_target  out  32  registered branch target.
REQ-016 if_id_write  out  1  fetch/decode register update enable.
REQ-017 if_id_flush  out  1  clear fetch/decode register to NOP.
REQ-018 id_ex_bubble  out  1  force NOP opcode (bit14) into decode/execute register.
REQ-019 halted  out  1  controller in HALT.
REQ-020 state  out  2  RUN=0, STALL=1, FLUSH=2, HALT=3.
REQ-021 stall_count  out  8  saturating count of STALL cycles.

Function
REQ-022 Outputs SHALL be Moore decodes of state plus registered pc_sel/pc_target: RUN pc_write=1, if_id_write=1, rest 0; STALL pc_write=0, if_id_write=0, id_ex_bubble=1; FLUSH pc_write=pc_sel, if_id_write=1, if_id_flush=1, id_ex_bubble=1; HALT pc_write=0, if_id_write=0, id_ex_bubble=1, halted=1.
REQ-023 A 4-bit down-counter cnt SHALL set STALL/FLUSH duration; state exits at the edge where cnt==1, so a load of N gives exactly N cycles.
REQ-024 RUN transition priority, evaluated each edge: ex_branch -> FLUSH (cnt=FLUSH_CYCLES, pc_target=ex_target, pc_sel=1); else id_valid & HLT -> HALT; else hazard -> STALL (cnt=1); else id_valid & MUL & MUL_CYCLES>1 -> STALL (cnt=MUL_CYCLES-1); else stay RUN.
REQ-025 Hazard SHALL be id_valid & (ex_opcode has any of bits 0-7,10,11,12 set) & (ex_dest==id_rs | ex_dest==id_rt); hazard and MUL together SHALL load cnt=max(1, MUL_CYCLES-1).
REQ-026 pc_sel SHALL be 1 only during the first FLUSH cycle and cleared on the following edge.
REQ-027 STALL: ex_branch=1 SHALL preempt to FLUSH per REQ-024; otherwise exit to RUN at cnt==1.
REQ-028 FLUSH: ex_branch SHALL be ignored; exit to RUN at cnt==1.
REQ-029 HALT: exit to RUN only on resume=1; ex_branch, id_valid ignored.
REQ-030 stall_count SHALL increment every cycle state==STALL and saturate at 255.
REQ-031 One-hot violation (zero or multiple bits set in id_opcode) SHALL be treated as NOP: no HLT/MUL action, hazard check still applies.

Reset
REQ-032 reset_n=0 SHALL immediately force state=RUN, cnt=0, pc_sel=0, pc_target=0, stall_count=0, independent of clock.
REQ-033 Reset asserted mid-STALL, mid-FLUSH or in HALT SHALL abandon the operation; first edge after release evaluates REQ-024 from RUN.

Verification
REQ-034 ex_opcode=ADD, ex_dest=5, id_valid=1, id_rs=5 -> exactly 1 STALL cycle (pc_write=0, id_ex_bubble=1), stall_count=1, then RUN.
REQ-035 id_opcode=MUL, MUL_CYCLES=3, no hazard -> 2 STALL cycles, then RUN; stall_count=2.
REQ-036 ex_branch=1, ex_target=0x00000040 in RUN -> FLUSH 2 cycles, cycle 1 pc_sel=1, pc_write=1, pc_target=0x40; cycle 2 pc_sel=0, pc_write=0; both if_id_flush=1.
REQ-037 ex_branch=1 with simultaneous HLT and hazard in RUN -> FLUSH taken; HALT not entered.
REQ-038 id_opcode=HLT -> HALT, halted=1, ex_branch pulses ignored; resume pulse -> RUN next edge, halted=0.
REQ-039 reset_n low during MUL STALL cnt=2 -> state=RUN asynchronously, stall_count=0; 300 consecutive hazard stalls -> stall_count holds 255.
